// File: rtl/fnd_scan_controller.sv
// ============================================================================
//  Module   : fnd_scan_controller
//  Purpose  : 4-digit multiplexed 7-segment scanner with anti-ghost blanking,
//             tear-free frame-synchronous loads and leading-zero blanking.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fnd_scan_controller #(
    parameter int DIV  = 100000,
    parameter int DEAD = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic        i_load,
    input  logic [15:0] i_value,
    input  logic [3:0]  i_dp,
    input  logic        i_lzb,
    output logic [3:0]  o_digit,
    output logic [7:0]  o_font,
    output logic        o_frame
);

    localparam int            CW         = $clog2(DIV);
    localparam logic [CW-1:0] c_cnt_last = CW'(DIV - 1);
    localparam logic [CW-1:0] c_cnt_dead = CW'(DEAD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   disp_q, disp_d, pend_q, pend_d;
    logic [3:0]    disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
    logic          pend_valid_q, pend_valid_d;
    logic [3:0]    digit_d;
    logic [7:0]    font_d;
    logic          frame_d;

    logic          w_scanning;
    logic          w_wrap;
    logic [3:0]    w_nibble;
    logic          w_lz;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    assign w_scanning = (state_q != IDLE);
    assign w_wrap     = w_scanning && i_en && (cnt_q == c_cnt_last) && (idx_q == 2'd3);

    // Scan sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        frame_d = 1'b0;
        if (!i_en) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = 2'd0;
        end else if (!w_scanning) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = 2'd0;
        end else begin
            if (cnt_q == c_cnt_last) begin
                cnt_d   = '0;
                idx_d   = idx_q + 2'd1;
                frame_d = (idx_q == 2'd3);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            state_d = (cnt_d < c_cnt_dead) ? BLANK : DRIVE;
        end
    end

    // Loads land directly when idle or at the frame seam, otherwise they wait in pend
    always_comb begin
        disp_d       = disp_q;
        disp_dp_d    = disp_dp_q;
        pend_d       = pend_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        if (i_load && (!w_scanning || w_wrap)) begin
            disp_d       = i_value;
            disp_dp_d    = i_dp;
            pend_valid_d = 1'b0;
        end else begin
            if (w_wrap && pend_valid_q) begin
                disp_d       = pend_q;
                disp_dp_d    = pend_dp_q;
                pend_valid_d = 1'b0;
            end
            if (i_load) begin
                pend_d       = i_value;
                pend_dp_d    = i_dp;
                pend_valid_d = 1'b1;
            end
        end
    end

    // Output image for the upcoming cycle, so registered outputs match that cycle's cnt
    always_comb begin
        w_nibble = disp_d[{idx_d, 2'b00} +: 4];
        case (idx_d)
            2'd1:    w_lz = (disp_d[15:4] == 12'h000);
            2'd2:    w_lz = (disp_d[15:8] == 8'h00);
            2'd3:    w_lz = (disp_d[15:12] == 4'h0);
            default: w_lz = 1'b0;
        endcase
        digit_d = 4'hF;
        font_d  = 8'hFF;
        if (state_d == DRIVE) begin
            digit_d = ~(4'b0001 << idx_d);
            if (!(i_lzb && w_lz)) begin
                font_d = {~disp_dp_d[idx_d], seg7(w_nibble)};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            disp_q       <= 16'h0000;
            disp_dp_q    <= 4'h0;
            pend_q       <= 16'h0000;
            pend_dp_q    <= 4'h0;
            pend_valid_q <= 1'b0;
            o_digit      <= 4'hF;
            o_font       <= 8'hFF;
            o_frame      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            disp_dp_q    <= disp_dp_d;
            pend_q       <= pend_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            o_digit      <= digit_d;
            o_font       <= font_d;
            o_frame      <= frame_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fnd_scan_controller.sv
// ============================================================================
//  Module   : tb_fnd_scan_controller
//  Purpose  : Self-checking bench for fnd_scan_controller (DIV=10, DEAD=2).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fnd_scan_controller;

    localparam int DIV   = 10;
    localparam int DEAD  = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst, en, ld, lzb;
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  o_digit;
    logic [7:0]  o_font;
    logic        o_frame;

    int errors = 0;
    int checks = 0;

    fnd_scan_controller #(.DIV(DIV), .DEAD(DEAD)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_en    (en),
        .i_load  (ld),
        .i_value (val),
        .i_dp    (dp),
        .i_lzb   (lzb),
        .o_digit (o_digit),
        .o_font  (o_font),
        .o_frame (o_frame)
    );

    always #5 clk = ~clk;

    // Reference model: position t within the 4*DIV frame since scan start
    logic [7:0]  font_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    bit          m_run;
    int          m_t;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_dp, m_pdp;
    bit          m_pv;
    logic [3:0]  m_digit;
    logic [7:0]  m_font;
    logic        m_frame;

    always @(posedge clk) begin
        bit wrap;
        int idx;
        if (rst) begin
            m_run = 0; m_t = 0; m_disp = 0; m_pend = 0; m_dp = 0; m_pdp = 0; m_pv = 0;
            m_digit = 4'hF; m_font = 8'hFF; m_frame = 1'b0;
        end else begin
            wrap = m_run && en && (m_t == FRAME - 1);
            if (ld && (!m_run || wrap)) begin
                m_disp = val; m_dp = dp; m_pv = 0;
            end else begin
                if (wrap && m_pv) begin m_disp = m_pend; m_dp = m_pdp; m_pv = 0; end
                if (ld) begin m_pend = val; m_pdp = dp; m_pv = 1; end
            end
            m_frame = wrap;
            if (!en)         begin m_run = 0; m_t = 0; end
            else if (!m_run) begin m_run = 1; m_t = 0; end
            else             m_t = (m_t + 1) % FRAME;
            m_digit = 4'hF;
            m_font  = 8'hFF;
            if (m_run && (m_t % DIV) >= DEAD) begin
                idx     = m_t / DIV;
                m_digit = 4'hF & ~(4'd1 << idx);
                if (!(lzb && idx != 0 && (m_disp >> (4 * idx)) == 0))
                    m_font = {~m_dp[idx], font_tbl[(m_disp >> (4 * idx)) & 16'hF][6:0]};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_t(input int t);
        int guard = 0;
        while (m_t != t && guard < 200) begin tick(); guard++; end
        if (m_t != t) begin
            errors++; checks++;
            $display("FAIL wait_t timeout: position %0d never reached (at %0d)", t, m_t);
        end
    endtask

    task automatic test_reset();
        rst = 1; en = 0; ld = 0; lzb = 0; val = 0; dp = 0;
        tick(); tick();
        checks++;
        if (o_digit !== 4'hF || o_font !== 8'hFF || o_frame !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got %h/%h/%b want F/FF/0", o_digit, o_font, o_frame);
        end
        rst = 0;
    endtask

    task automatic test_basic_scan();
        int frames = 0;
        ld = 1; val = 16'h1234; dp = 4'h0; tick(); ld = 0;
        en = 1; tick(); tick(); tick();
        checks++;
        if (o_digit !== 4'hE || o_font !== 8'h99) begin
            errors++;
            $display("FAIL first_drive got %h/%h want E/99", o_digit, o_font);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            frames += int'(o_frame);
            checks++;
            if (o_digit !== m_digit || o_font !== m_font || o_frame !== m_frame) begin
                errors++;
                $display("FAIL basic t=%0d got %h/%h/%b want %h/%h/%b",
                         m_t, o_digit, o_font, o_frame, m_digit, m_font, m_frame);
            end
        end
        checks++;
        if (frames != 2) begin
            errors++;
            $display("FAIL frame_count got %0d want 2", frames);
        end
    endtask

    task automatic test_midframe_load();
        wait_t(15);
        ld = 1; val = 16'hABCD; tick(); ld = 0;
        wait_t(18);
        checks++;
        if (o_font !== 8'hB0) begin
            errors++; $display("FAIL no_tear got %h want B0", o_font);
        end
        wait_t(2);
        checks++;
        if (o_font !== 8'hA1) begin
            errors++; $display("FAIL next_frame got %h want A1", o_font);
        end
        wait_t(FRAME - 1);
        ld = 1; val = 16'h5678; tick(); ld = 0;
        for (int i = 0; i < FRAME + 5; i++) begin
            tick();
            checks++;
            if (o_digit !== m_digit || o_font !== m_font || o_frame !== m_frame) begin
                errors++;
                $display("FAIL wrap_load t=%0d got %h/%h/%b want %h/%h/%b",
                         m_t, o_digit, o_font, o_frame, m_digit, m_font, m_frame);
            end
        end
    endtask

    task automatic test_lzb_dp(input logic [15:0] v, input logic [3:0] d, input logic z,
                               input logic [7:0] f3, input logic [7:0] f0);
        en = 0; tick();
        ld = 1; val = v; dp = d; lzb = z; tick(); ld = 0;
        en = 1;
        for (int i = 0; i < FRAME + 2; i++) begin
            tick();
            checks++;
            if (o_digit !== m_digit || o_font !== m_font || o_frame !== m_frame) begin
                errors++;
                $display("FAIL lzb_dp v=%h t=%0d got %h/%h/%b want %h/%h/%b",
                         v, m_t, o_digit, o_font, o_frame, m_digit, m_font, m_frame);
            end
            if (m_t == 35 || m_t == 5) begin
                checks++;
                if (o_font !== ((m_t == 35) ? f3 : f0)) begin
                    errors++;
                    $display("FAIL lzb_dp_const v=%h t=%0d got %h want %h",
                             v, m_t, o_font, (m_t == 35) ? f3 : f0);
                end
            end
        end
        lzb = 0; dp = 0;
    endtask

    task automatic test_reset_midslot();
        wait_t(24);
        rst = 1; tick(); rst = 0;
        checks++;
        if (o_digit !== 4'hF || o_font !== 8'hFF || o_frame !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got %h/%h/%b want F/FF/0", o_digit, o_font, o_frame);
        end
        tick(); tick();
        checks++;
        if (o_digit !== 4'hF) begin
            errors++; $display("FAIL reset_dead got %h want F", o_digit);
        end
        tick();
        checks++;
        if (o_digit !== 4'hE || o_font !== 8'hC0) begin
            errors++; $display("FAIL reset_restart got %h/%h want E/C0", o_digit, o_font);
        end
    endtask

    task automatic test_enable_drop();
        en = 0; tick();
        ld = 1; val = 16'h00A7; tick(); ld = 0;
        en = 1;
        wait_t(25);
        en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (o_digit !== 4'hF || o_font !== 8'hFF) begin
                errors++; $display("FAIL en_drop got %h/%h want F/FF", o_digit, o_font);
            end
        end
        en = 1; tick(); tick(); tick();
        checks++;
        if (o_digit !== 4'hE || o_font !== 8'hF8) begin
            errors++; $display("FAIL en_resume got %h/%h want E/F8", o_digit, o_font);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 29) != 0);
            ld  = ($urandom_range(0, 9) == 0);
            val = 16'($urandom);
            dp  = 4'($urandom);
            if ($urandom_range(0, 99) == 0) lzb = ~lzb;
            tick();
            checks++;
            if (o_digit !== m_digit || o_font !== m_font || o_frame !== m_frame) begin
                errors++;
                $display("FAIL random i=%0d got %h/%h/%b want %h/%h/%b",
                         i, o_digit, o_font, o_frame, m_digit, m_font, m_frame);
            end
        end
        rst = 0; ld = 0;
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_midframe_load();
        test_lzb_dp(16'h0050, 4'b0000, 1'b1, 8'hFF, 8'hC0);
        test_lzb_dp(16'h0000, 4'b0000, 1'b1, 8'hFF, 8'hC0);
        test_lzb_dp(16'h8888, 4'b0101, 1'b0, 8'h80, 8'h00);
        test_reset_midslot();
        test_enable_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
